// File: rtl/add_serial_driver_if.sv
// rtl/add_serial_driver_if.sv - operand, adder and result bus between add_serial_driver and its neighbours
interface add_serial_driver_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             add_en;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_out;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             busy;

    modport master (
        input  in_valid, in_a, in_b, add_out, res_ready,
        output in_ready, add_en, add_a, add_b, res_valid, res_data, busy
    );

    modport slave (
        output in_valid, in_a, in_b, add_out, res_ready,
        input  in_ready, add_en, add_a, add_b, res_valid, res_data, busy
    );
endinterface

// File: rtl/add_serial_driver.sv
// rtl/add_serial_driver.sv - operand FIFO, launch/wait/hold sequencer and result capture for add_serial
module add_serial_driver #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LAT   = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    add_serial_driver_if.master  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
    localparam logic [PW-1:0] ONE_P    = PW'(1);
    localparam logic [TW-1:0] ONE_T    = TW'(1);
    localparam logic [TW-1:0] LOAD_T   = TW'(LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_HOLD} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count, count_next;
    logic             in_ready_q;
    logic [WIDTH-1:0] add_a_q, add_b_q;
    logic [WIDTH-1:0] head_a, head_b;
    logic [TW-1:0]    cnt;
    logic             res_valid_q;
    logic [WIDTH-1:0] res_data_q;
    logic             push, pop;

    assign push = bus.in_valid && in_ready_q;
    assign pop  = (state == S_LAUNCH);

    // An empty FIFO being written this cycle can only launch from HOLD; bypass the write.
    assign head_a = (count == '0) ? bus.in_a : mem_a[rd_ptr];
    assign head_b = (count == '0) ? bus.in_b : mem_b[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + ONE_C;
        end else if (!push && pop) begin
            count_next = count - ONE_C;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (count != '0) state_next = S_LAUNCH;
            S_LAUNCH: state_next = S_WAIT;
            S_WAIT:   if (cnt == '0) state_next = S_HOLD;
            S_HOLD: begin
                if (bus.res_ready) begin
                    state_next = (count_next != '0) ? S_LAUNCH : S_IDLE;
                end
            end
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= bus.in_a;
            mem_b[wr_ptr] <= bus.in_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            in_ready_q  <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            cnt         <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            in_ready_q <= (count_next != FULL_C);
            if (push) wr_ptr <= wr_ptr + ONE_P;
            if (pop)  rd_ptr <= rd_ptr + ONE_P;

            if (state_next == S_LAUNCH) begin
                add_a_q <= head_a;
                add_b_q <= head_b;
            end

            if (state == S_LAUNCH) begin
                cnt <= LOAD_T;
            end else if (state == S_WAIT && cnt != '0) begin
                cnt <= cnt - ONE_T;
            end

            if (state == S_WAIT && cnt == '0) begin
                res_data_q  <= bus.add_out;
                res_valid_q <= 1'b1;
            end else if (state == S_HOLD && bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.add_en    = (state == S_LAUNCH);
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.busy      = (state != S_IDLE) || (count != '0);
endmodule

// File: tb/tb_add_serial_driver.sv
// tb/tb_add_serial_driver.sv - directed bench for add_serial_driver with a 9-cycle behavioural adder
module tb_add_serial_driver;
    localparam int WIDTH = 8;
    localparam int LAT   = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    add_serial_driver_if #(.WIDTH(WIDTH)) bus ();

    add_serial_driver #(.WIDTH(WIDTH), .DEPTH(4), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int push_count = 0;
    int res_count  = 0;
    int en_count   = 0;
    logic prev_en  = 1'b0;
    logic [7:0] exp_q [$];
    logic [7:0] res_log [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural adder: sum appears 9 cycles after the enable edge, zero meanwhile.
    int         add_cnt;
    logic [7:0] add_acc;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            add_cnt     <= 0;
            add_acc     <= '0;
            bus.add_out <= '0;
        end else if (bus.add_en) begin
            add_cnt     <= 9;
            add_acc     <= bus.add_a + bus.add_b;
            bus.add_out <= '0;
        end else if (add_cnt != 0) begin
            add_cnt <= add_cnt - 1;
            if (add_cnt == 1) bus.add_out <= add_acc;
        end
    end

    always @(negedge clk) begin
        logic [7:0] s;
        if (rst) begin
            exp_q.delete();
            prev_en = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                s = 8'(bus.in_a + bus.in_b);
                exp_q.push_back(s);
                push_count++;
            end
            if (bus.res_valid && bus.res_ready) begin
                res_count++;
                res_log.push_back(bus.res_data);
                if (exp_q.size() == 0) check("res_spurious", 1, 0);
                else check("res_order", bus.res_data, exp_q.pop_front());
            end
            if (bus.add_en) begin
                en_count++;
                check("en_back2back", prev_en, 0);
                check("en_while_res", bus.res_valid, 0);
            end
            prev_en = bus.add_en;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] a, input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        tick();
    endtask

    task automatic wait_res(input string tag, input int limit);
        int n = 0;
        while (!bus.res_valid && n < limit) begin tick(); n++; end
        check(tag, bus.res_valid, 1);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while ((bus.busy || bus.res_valid) && n < limit) begin tick(); n++; end
        check(tag, bus.busy || bus.res_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_seen, rv_at, p0, r0, e0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.res_ready = 1'b0;
        tick(); tick();
        check("rst_add_en", bus.add_en, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_busy", bus.busy, 0);
        rst = 1'b0;
        tick();
        check("rst_in_ready", bus.in_ready, 1);

        // Single op: latency and single enable pulse
        bus.res_ready = 1'b1;
        put(8'h15, 8'h2A);
        bus.in_valid = 1'b0;
        en_seen = 0; rv_at = 0;
        for (int k = 1; k <= LAT + 3; k++) begin
            tick();
            if (bus.add_en) begin
                en_seen++;
                check("t1_en_cycle", k, 1);
                check("t1_add_a", bus.add_a, 8'h15);
                check("t1_add_b", bus.add_b, 8'h2A);
            end
            if (bus.res_valid && rv_at == 0) begin
                rv_at = k;
                check("t1_res_data", bus.res_data, 8'h3F);
            end
        end
        check("t1_en_count", en_seen, 1);
        check("t1_res_latency", rv_at, LAT + 2);
        check("t1_busy_after", bus.busy, 0);

        // FIFO full while held, then push/pop collision on the launch cycle
        p0 = push_count; r0 = res_count;
        bus.res_ready = 1'b0;
        put(8'h01, 8'h02);
        bus.in_valid = 1'b0;
        wait_res("t2_wait_p0", 40);
        put(8'h10, 8'h01);
        put(8'h20, 8'h02);
        put(8'h30, 8'h03);
        check("t2_ready_before_4th", bus.in_ready, 1);
        put(8'h40, 8'h04);
        check("t2_ready_full", bus.in_ready, 0);
        bus.in_a = 8'h50; bus.in_b = 8'h05;
        tick(); tick(); tick();
        check("t2_ready_still_full", bus.in_ready, 0);
        check("t2_dropped", push_count - p0, 5);
        bus.res_ready = 1'b1;
        tick();
        check("t2_launch_en", bus.add_en, 1);
        check("t2_launch_ready", bus.in_ready, 0);
        tick();
        check("t2_ready_reassert", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        wait_idle("t2_drain", 200);
        check("t2_push_total", push_count - p0, 6);
        check("t2_res_total", res_count - r0, 6);
        check("t2_last_res", res_log[res_log.size()-1], 8'h55);

        // Backpressure: 20 held cycles with two pairs queued
        bus.res_ready = 1'b0;
        put(8'h10, 8'h20);
        put(8'h03, 8'h04);
        put(8'h05, 8'h06);
        bus.in_valid = 1'b0;
        wait_res("t3_wait", 40);
        e0 = en_count;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("t3_hold_data", bus.res_data, 8'h30);
        end
        check("t3_no_en", en_count - e0, 0);
        bus.res_ready = 1'b1;
        tick();
        check("t3_next_launch", bus.add_en, 1);
        check("t3_next_a", bus.add_a, 8'h03);
        check("t3_next_b", bus.add_b, 8'h04);
        wait_idle("t3_drain", 100);
        check("t3_res_b", res_log[res_log.size()-2], 8'h07);
        check("t3_res_c", res_log[res_log.size()-1], 8'h0B);

        // Wrap-around sums pass through verbatim
        put(8'hFF, 8'h01);
        put(8'h80, 8'h80);
        put(8'h7F, 8'h01);
        bus.in_valid = 1'b0;
        wait_idle("t4_drain", 100);
        check("t4_ff_01", res_log[res_log.size()-3], 8'h00);
        check("t4_80_80", res_log[res_log.size()-2], 8'h00);
        check("t4_7f_01", res_log[res_log.size()-1], 8'h80);

        // Reset four cycles into WAIT with two pairs queued
        put(8'h11, 8'h11);
        put(8'h22, 8'h22);
        put(8'h33, 8'h33);
        bus.in_valid = 1'b0;
        while (!bus.add_en) tick();
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        #1;
        check("t5_rst_add_en", bus.add_en, 0);
        check("t5_rst_add_a", bus.add_a, 0);
        check("t5_rst_add_b", bus.add_b, 0);
        check("t5_rst_res_valid", bus.res_valid, 0);
        check("t5_rst_res_data", bus.res_data, 0);
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_in_ready", bus.in_ready, 0);
        tick();
        rst = 1'b0;
        r0 = res_count; e0 = en_count;
        tick();
        check("t5_in_ready_after", bus.in_ready, 1);
        for (int k = 0; k < 30; k++) tick();
        check("t5_no_en", en_count - e0, 0);
        check("t5_no_res", res_count - r0, 0);
        check("t5_res_valid_low", bus.res_valid, 0);
        put(8'h21, 8'h21);
        bus.in_valid = 1'b0;
        wait_idle("t5_fresh_drain", 100);
        check("t5_fresh_res", res_log[res_log.size()-1], 8'h42);
        check("t5_fresh_count", res_count - r0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/add_serial_driver.md
Name: add_serial_driver

Overview:
Operand-issue and result-capture stage that sits directly in front of the `add_serial` serial adder.
- Buffers operand pairs from an upstream valid/ready source in a small FIFO.
- Launches each pair into the adder with a one-cycle enable pulse.
- Waits a fixed, parameterised number of cycles for the serial add to finish.
- Samples the adder's `out` bus and presents it downstream on a valid/ready result port.
- Only one addition is in flight at a time.

Parameters:
- WIDTH, 8: operand and result width; must match the adder.
- DEPTH, 4: operand FIFO depth in pairs; power of two, ≥2.
- LAT, 10: cycles from the launch cycle to the result sample; ≥1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  upstream operand pair valid.
- in_ready  output  1  FIFO can accept a pair (registered, = !full).
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- add_en  output  1  enable pulse to the adder.
- add_a  output  WIDTH  operand A to the adder.
- add_b  output  WIDTH  operand B to the adder.
- add_out  input  WIDTH  result bus from the adder.
- res_valid  output  1  result valid.
- res_ready  input  1  downstream accepts the result.
- res_data  output  WIDTH  captured sum.
- busy  output  1  high whenever state != IDLE or the FIFO is non-empty.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE; FIFO emptied (rd/wr pointers = 0, count = 0).
  - add_en = 0, add_a = 0, add_b = 0, res_valid = 0, res_data = 0.
  - Wait counter = 0; in_ready = 1 after release.
- FIFO:
  - Push when in_valid && in_ready.
  - in_ready derives from the registered count, so a push offered while full is rejected, even in a cycle that pops.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- FSM states: IDLE, LAUNCH, WAIT, HOLD.
- IDLE:
  - add_en = 0.
  - If FIFO non-empty, go to LAUNCH next cycle.
- LAUNCH (exactly one cycle):
  - add_en = 1.
  - add_a and add_b are registered from the FIFO head on entry, so they are valid in this cycle.
  - Pop the FIFO head.
  - Load the counter with LAT-1.
  - Go to WAIT.
- WAIT:
  - add_en = 0; add_a and add_b hold the launched values, stable until the next LAUNCH.
  - If counter == 0: res_data <= add_out, res_valid <= 1, go to HOLD.
  - Otherwise decrement the counter.
  - WAIT lasts exactly LAT cycles.
- HOLD:
  - res_valid = 1; res_data stays stable until the handshake.
  - On res_valid && res_ready: res_valid <= 0. Go to LAUNCH if the FIFO is non-empty after any same-cycle push, else go to IDLE.
  - While res_ready = 0, no new add_en is issued.
- Timing:
  - A pair pushed into an empty FIFO at edge t puts the FSM in LAUNCH during cycle t+1.
  - res_valid rises at edge t+LAT+2.
  - Back-to-back throughput is one result per LAT+2 cycles with res_ready tied high.
- Arithmetic: none is performed internally. res_data is add_out verbatim; WIDTH-bit wrap-around is the adder's concern.
- Reset mid-operation:
  - Immediately abandons any in-flight add and drops res_valid.
  - Discards all buffered pairs.
  - No add_en is issued until a new push.
- Never assert add_en in two consecutive cycles.
- Never assert add_en while res_valid = 1.

Test Plan:
- Single op: push a=0x15, b=0x2A, with a behavioural adder model returning a+b after 9 cycles.
  → add_en is high for exactly one cycle with add_a=0x15, add_b=0x2A.
  → res_valid rises LAT+2 cycles after the push with res_data=0x3F.
  → busy is low after the handshake.
- FIFO full: push 4 pairs with res_ready=0.
  → in_ready goes low after the 4th push (one pair launches, so it reasserts after the first pop).
  → a 5th push offered while in_ready=0 is dropped; the total result count equals accepted pushes.
- Backpressure: after res_valid, hold res_ready=0 for 20 cycles with 2 pairs queued.
  → res_data stays constant and no add_en is issued.
  → after res_ready=1, LAUNCH of the next pair occurs in the following cycle.
- Wrap-around: a=0xFF, b=0x01, adder model returns 0x00.
  → res_data=0x00.
  → then a=0x80, b=0x80 → res_data=0x00.
  → then a=0x7F, b=0x01 → res_data=0x80.
- Reset mid-WAIT: assert rst 4 cycles after add_en with 2 pairs queued.
  → all outputs return to 0 asynchronously and in_ready=1 after release.
  → no add_en or res_valid occurs until a fresh push.
- Full push/pop collision: FIFO full; LAUNCH pops while in_valid=1.
  → the push is rejected that cycle and accepted the next cycle.
  → data ordering is preserved (results match push order).
